instr_fetch_unit: RTL

//  Fetch stage feeding the MIPS decoder/controller: owns the PC, issues word reads to

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/instr_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types, instruction field positions and PC-target helpers for the fetch stage.
// Pure declarations: no state, no latency, no flow control.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        KILL
    } fetch_state_t;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JIDX_MSB  = 25;
    localparam int JIDX_LSB  = 0;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] jidx);
        return {pc_hi, jidx, 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pcplus4, input logic [15:0] imm);
        return pcplus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry {instr,pc} buffer; registered, head visible the cycle after push.
// Caller must not push when full; flush has priority over push; empty output holds last head.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output fetch_entry_t     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     hold_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '{instr: 32'h0, pc: RESET_PC};
        end else begin
            if (valid) begin
                hold_q <= mem_q[rd_ptr_q];
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= next_ptr(wr_ptr_q);
                end
                if (pop && valid) begin
                    rd_ptr_q <= next_ptr(rd_ptr_q);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop && valid);
            end
        end
    end

    assign count = count_q;
    assign valid = (count_q != '0);
    assign head  = valid ? mem_q[rd_ptr_q] : hold_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem read, 2-entry buffer to decode, self-redirects.
// Latency rvalid -> instr_valid one cycle; stops requesting while the buffer is full.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic [CNT_W-1:0] count, count_after;
    logic             push, retire, redirect;
    logic [31:0]      target;
    fetch_entry_t     head;

    assign retire      = instr_valid & instr_ready;
    assign redirect    = retire & (jump | pcsrc);
    assign target      = jump ? jump_target(pcplus4[31:28], instr[JIDX_MSB:JIDX_LSB])
                              : branch_target(pcplus4, instr[IMM_MSB:IMM_LSB]);
    assign count_after = count + CNT_W'(1) - CNT_W'(retire);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_pc_d   = out_pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect || count < CNT_W'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    out_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + WORD_BYTES;
                    state_d    = redirect ? KILL : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = !redirect;
                    state_d = (redirect || count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
                end else if (redirect) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                // The in-flight word belongs to the old path; swallow it before refetching.
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            out_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
        end
    end

    instr_fifo #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ('{instr: imem_rdata, pc: out_pc_q}),
        .pop      (retire),
        .flush    (redirect),
        .count    (count),
        .valid    (instr_valid),
        .head     (head)
    );

    assign imem_req  = (state_q == REQ);
    assign imem_addr = fetch_pc_q;
    assign instr     = head.instr;
    assign pc        = head.pc;
    assign pcplus4   = head.pc + WORD_BYTES;
    assign op        = head.instr[OP_MSB:OP_LSB];
    assign funct     = head.instr[FUNCT_MSB:FUNCT_LSB];

endmodule
